// File: rtl/qkd_sifter_param.sv
// QKD basis sifter: keeps raw pairs whose bases match, stores them in key memory, tracks block statistics.
// Optional feature: define QBER_ABORT_EN to abort a block once err_count reaches ERR_LIMIT.
module qkd_sifter_param #(
    parameter int ADDR_W    = 10,
    parameter int KEY_LEN   = 1024,
    parameter int BASIS_W   = 1,
    parameter int ERR_LIMIT = 110
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BASIS_W-1:0] alice_basis,
    input  logic [BASIS_W-1:0] bob_basis,
    input  logic               alice_bit,
    input  logic               bob_bit,
    output logic               key_we,
    output logic [ADDR_W-1:0]  key_addr,
    output logic               key_a,
    output logic               key_b,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_a,
    output logic               rd_b,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [ADDR_W:0]    key_count,
    output logic [ADDR_W:0]    err_count,
    output logic [15:0]        disc_count
);

    typedef enum logic [1:0] {IDLE, SIFT, DONE, ABORT} state_t;

    state_t              state_reg;
    logic                in_ready_reg, busy_reg, done_reg, aborted_reg;
    logic                key_we_reg, key_a_reg, key_b_reg;
    logic [ADDR_W-1:0]   key_addr_reg;
    logic [1:0]          rd_data_reg;
    logic [ADDR_W:0]     key_count_reg, err_count_reg;
    logic [15:0]         disc_count_reg;
    logic [1:0]          mem [0:(1<<ADDR_W)-1];

    logic                accept, basis_match, bit_err, hit_len, hit_err;
    logic [ADDR_W:0]     key_count_next, err_count_next;

    // A start in the same cycle as a beat restarts the block and drops the beat.
    assign accept         = in_valid && in_ready_reg && !start;
    assign basis_match    = (alice_basis == bob_basis);
    assign bit_err        = alice_bit ^ bob_bit;
    assign key_count_next = key_count_reg + 1'b1;
    assign err_count_next = err_count_reg + {{ADDR_W{1'b0}}, bit_err};
    assign hit_len        = (int'(key_count_next) == KEY_LEN);

`ifdef QBER_ABORT_EN
    assign hit_err = bit_err && (int'(err_count_next) == ERR_LIMIT);
`else
    logic unused_err_limit;
    assign unused_err_limit = (ERR_LIMIT != 0);
    assign hit_err          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            in_ready_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            aborted_reg    <= 1'b0;
            key_we_reg     <= 1'b0;
            key_addr_reg   <= '0;
            key_a_reg      <= 1'b0;
            key_b_reg      <= 1'b0;
            key_count_reg  <= '0;
            err_count_reg  <= '0;
            disc_count_reg <= '0;
        end else begin
            key_we_reg <= 1'b0;
            if (start) begin
                state_reg      <= SIFT;
                in_ready_reg   <= 1'b1;
                busy_reg       <= 1'b1;
                done_reg       <= 1'b0;
                aborted_reg    <= 1'b0;
                key_count_reg  <= '0;
                err_count_reg  <= '0;
                disc_count_reg <= '0;
            end else if (accept) begin
                if (basis_match) begin
                    key_we_reg    <= 1'b1;
                    key_addr_reg  <= key_count_reg[ADDR_W-1:0];
                    key_a_reg     <= alice_bit;
                    key_b_reg     <= bob_bit;
                    key_count_reg <= key_count_next;
                    err_count_reg <= err_count_next;
                    // Abort wins over completion when both trigger on the same pair.
                    if (hit_err) begin
                        state_reg    <= ABORT;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        aborted_reg  <= 1'b1;
                    end else if (hit_len) begin
                        state_reg    <= DONE;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                    end
                end else if (disc_count_reg != 16'hFFFF) begin
                    disc_count_reg <= disc_count_reg + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && basis_match)
            mem[key_count_reg[ADDR_W-1:0]] <= {alice_bit, bob_bit};
    end

    // Read-before-write: a same-address read in the write cycle sees the old pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data_reg <= 2'b00;
        else
            rd_data_reg <= mem[rd_addr];
    end

    assign in_ready   = in_ready_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign aborted    = aborted_reg;
    assign key_we     = key_we_reg;
    assign key_addr   = key_addr_reg;
    assign key_a      = key_a_reg;
    assign key_b      = key_b_reg;
    assign rd_a       = rd_data_reg[1];
    assign rd_b       = rd_data_reg[0];
    assign key_count  = key_count_reg;
    assign err_count  = err_count_reg;
    assign disc_count = disc_count_reg;

endmodule

// File: tb/tb_qkd_sifter_param.sv
// Self-checking bench for qkd_sifter_param: vector table of beats, write scoreboard, status checks.
module tb_qkd_sifter_param;

    localparam int ADDR_W    = 4;
    localparam int KEY_LEN   = 12;
    localparam int BASIS_W   = 2;
    localparam int ERR_LIMIT = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [BASIS_W-1:0] alice_basis = '0;
    logic [BASIS_W-1:0] bob_basis = '0;
    logic               alice_bit = 1'b0;
    logic               bob_bit = 1'b0;
    logic               key_we;
    logic [ADDR_W-1:0]  key_addr;
    logic               key_a, key_b;
    logic [ADDR_W-1:0]  rd_addr = '0;
    logic               rd_a, rd_b;
    logic               busy, done, aborted;
    logic [ADDR_W:0]    key_count, err_count;
    logic [15:0]        disc_count;

    qkd_sifter_param #(
        .ADDR_W(ADDR_W), .KEY_LEN(KEY_LEN), .BASIS_W(BASIS_W), .ERR_LIMIT(ERR_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .alice_basis(alice_basis), .bob_basis(bob_basis), .alice_bit(alice_bit), .bob_bit(bob_bit),
        .key_we(key_we), .key_addr(key_addr), .key_a(key_a), .key_b(key_b),
        .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
        .busy(busy), .done(done), .aborted(aborted),
        .key_count(key_count), .err_count(err_count), .disc_count(disc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BASIS_W-1:0] ab;
        logic [BASIS_W-1:0] bb;
        logic               a;
        logic               b;
        logic               exp_wr;
        logic [ADDR_W-1:0]  exp_addr;
    } vec_t;

    vec_t vecs [0:63];
    int   nvec = 0;
    logic [ADDR_W+1:0] exp_q [$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int ab, input int bb, input logic a, input logic b,
                       input logic wr, input int addr);
        vecs[nvec] = '{BASIS_W'(ab), BASIS_W'(bb), a, b, wr, ADDR_W'(addr)};
        nvec++;
    endtask

    // Drive one beat for one cycle; returns 1 time unit after the sampling edge.
    task automatic send(input vec_t v);
        in_valid    = 1'b1;
        alice_basis = v.ab;
        bob_basis   = v.bb;
        alice_bit   = v.a;
        bob_bit     = v.b;
        if (v.exp_wr) exp_q.push_back({v.exp_addr, v.a, v.b});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send(vecs[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Scoreboard: every key_we must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && key_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0d a=%0d b=%0d expected no write",
                         key_addr, key_a, key_b);
            end else begin
                logic [ADDR_W+1:0] e;
                e = exp_q.pop_front();
                $display("write addr=%0d a=%0d b=%0d", key_addr, key_a, key_b);
                if ({key_addr, key_a, key_b} !== e) begin
                    bad++;
                    $display("FAIL write_data: got addr=%0d a=%0d b=%0d expected addr=%0d a=%0d b=%0d",
                             key_addr, key_a, key_b, e[ADDR_W+1:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        // 0..7: equal bases, equal bits, addresses 0..7
        for (int i = 0; i < 8; i++) add(i % 4, i % 4, i[0], i[0], 1'b1, i);
        // 8..21: 14 matched beats against KEY_LEN=12
        for (int i = 0; i < 14; i++) add(1, 1, i[1], i[1], (i < KEY_LEN), (i < KEY_LEN) ? i : 0);
        // 22..25: mixed bases
        add(2, 2, 1, 1, 1, 0);
        add(1, 3, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1);
        add(3, 1, 1, 1, 0, 0);
        // 26..30: matched bases, every bit mismatched
        for (int i = 0; i < 5; i++) begin
`ifdef QBER_ABORT_EN
            add(0, 0, 1, 0, (i < ERR_LIMIT), (i < ERR_LIMIT) ? i : 0);
`else
            add(0, 0, 1, 0, 1, i);
`endif
        end
        // 31..33: key_a pattern 1,0,1; 34: overwrite of address 0
        add(1, 1, 1, 1, 1, 0);
        add(1, 1, 0, 0, 1, 1);
        add(1, 1, 1, 1, 1, 2);
        add(2, 2, 0, 0, 1, 0);

        // Reset state
        idle(3);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_key_we", key_we, 0);
        chk("rst_key_addr", key_addr, 0);
        chk("rst_rd", {rd_a, rd_b}, 0);
        rst_n = 1'b1;
        idle(1);
        chk("rst_done_abort", {done, aborted}, 0);
        chk("rst_counts", {key_count, err_count, disc_count}, 0);

        // Beat in IDLE is ignored
        v = vecs[0]; v.exp_wr = 1'b0;
        send(v);
        idle(1);
        chk("idle_key_count", key_count, 0);

        // Eight equal-basis beats
        pulse_start();
        chk("sift_in_ready", in_ready, 1);
        run_vecs(0, 7);
        idle(2);
        chk("t8_key_count", key_count, 8);
        chk("t8_err_count", err_count, 0);
        chk("t8_disc_count", disc_count, 0);
        chk("t8_busy", busy, 1);
        chk("t8_queue", exp_q.size(), 0);

        // start in SIFT with a beat present: beat dropped, counters cleared
        in_valid = 1'b1; alice_basis = 2'd1; bob_basis = 2'd1;
        pulse_start();
        in_valid = 1'b0;
        idle(2);
        chk("restart_key_count", key_count, 0);
        chk("restart_busy", busy, 1);

        // KEY_LEN boundary with back-to-back beats
        run_vecs(8, 18);
        chk("len_pre_done", done, 0);
        run_vecs(19, 19);
        chk("len_done", done, 1);
        chk("len_in_ready", in_ready, 0);
        chk("len_busy", busy, 0);
        run_vecs(20, 21);
        idle(2);
        chk("len_key_count", key_count, KEY_LEN);
        chk("len_queue", exp_q.size(), 0);

        // Basis mismatch discards
        pulse_start();
        chk("basis_done_cleared", done, 0);
        run_vecs(22, 25);
        idle(2);
        chk("basis_key_count", key_count, 2);
        chk("basis_disc_count", disc_count, 2);
        chk("basis_queue", exp_q.size(), 0);

        // Bit errors
        pulse_start();
        run_vecs(26, 30);
        idle(2);
`ifdef QBER_ABORT_EN
        chk("err_aborted", aborted, 1);
        chk("err_err_count", err_count, ERR_LIMIT);
        chk("err_key_count", key_count, ERR_LIMIT);
        chk("err_in_ready", {in_ready, busy}, 0);
        pulse_start();
        chk("err_restart_aborted", aborted, 0);
        chk("err_restart_counts", {key_count, err_count, disc_count}, 0);
        chk("err_restart_busy", {in_ready, busy}, 2'b11);
`else
        chk("err_aborted", aborted, 0);
        chk("err_err_count", err_count, 5);
        chk("err_key_count", key_count, 5);
        chk("err_busy", busy, 1);
`endif
        chk("err_queue", exp_q.size(), 0);

        // Readback
        pulse_start();
        run_vecs(31, 33);
        idle(1);
        rd_addr = 4'd0; idle(1); chk("rd0", rd_a, 1);
        rd_addr = 4'd1; idle(1); chk("rd1", rd_a, 0);
        rd_addr = 4'd2; idle(1); chk("rd2", rd_a, 1);
        pulse_start();
        rd_addr = 4'd0;
        send(vecs[34]);
        chk("rdw_old", {rd_a, rd_b}, 2'b11);
        idle(1);
        chk("rdw_new", {rd_a, rd_b}, 2'b00);
        chk("rdw_queue", exp_q.size(), 0);

        // Reset mid-block
        pulse_start();
        run_vecs(0, 4);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", {in_ready, busy, done, aborted, key_we}, 0);
        chk("mid_rst_data", {key_addr, key_a, key_b, rd_a, rd_b}, 0);
        chk("mid_rst_counts", {key_count, err_count, disc_count}, 0);
        @(posedge clk); #1;
        v = vecs[0]; v.exp_wr = 1'b0;
        send(v);
        rst_n = 1'b1;
        idle(1);
        send(v);
        idle(1);
        chk("post_rst_idle_count", key_count, 0);
        pulse_start();
        run_vecs(0, 1);
        idle(2);
        chk("post_rst_key_count", key_count, 2);
        chk("post_rst_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qkd_sifter_param.md
QKD_SIFTER_PARAM -- requirements
Module: qkd_sifter_param

Interface
REQ-001 Parameter ADDR_W, default 10, key memory address width.
REQ-002 Parameter KEY_LEN, default 1024, sifted pairs per block (2..2^ADDR_W).
REQ-003 Parameter BASIS_W, default 1, basis index width; 1 = BB84, 2 = up to 4 bases.
REQ-004 Parameter ERR_LIMIT, default 110, mismatch count that aborts a block (QBER_ABORT_EN only).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 start  in  1  one-cycle pulse; opens a new block.
REQ-008 in_valid  in  1  raw pair present.
REQ-009 in_ready  out  1  block accepts raw pairs.
REQ-010 alice_basis, bob_basis  in  BASIS_W each  basis choices.
REQ-011 alice_bit, bob_bit  in  1 each  measured bits.
REQ-012 key_we  out  1  sifted pair written this cycle.
REQ-013 key_addr  out  ADDR_W  write address of the sifted pair.
REQ-014 key_a, key_b  out  1 each  sifted bits written.
REQ-015 rd_addr  in  ADDR_W  readback address; rd_a, rd_b  out  1 each  readback data.
REQ-016 busy, done, aborted  out  1 each  status flags.
REQ-017 key_count, err_count  out  ADDR_W+1 each; disc_count  out  16  block statistics.

Function
REQ-018 FSM states: IDLE, SIFT, DONE, ABORT. start moves IDLE/DONE/ABORT to SIFT.
REQ-019 Entry into SIFT clears key_count, err_count, disc_count, done, aborted.
REQ-020 in_ready = 1 only in SIFT; a beat is accepted when in_valid & in_ready.
REQ-021 Accepted beat with alice_basis == bob_basis (all BASIS_W bits): write the bit pair to memory at key_count, key_count +1, err_count +1 if alice_bit != bob_bit.
REQ-022 Accepted beat with differing basis: no write, disc_count +1, saturates at 65535.
REQ-023 key_we, key_addr, key_a, key_b are registered; they are valid exactly 1 cycle after the accepting edge; key_we = 0 otherwise.
REQ-024 The accept that makes key_count reach KEY_LEN moves SIFT to DONE on the same edge; in_ready is 0 from the next cycle on; no beat is accepted beyond KEY_LEN.
REQ-025 DONE: done = 1, busy = 0, counters hold; DONE stays until start.
REQ-026 busy = 1 exactly in SIFT.
REQ-027 start in SIFT restarts the block: counters cleared, state stays SIFT, any beat in that cycle is dropped and not counted.
REQ-028 Readback: rd_a/rd_b registered from memory[rd_addr], 1-cycle latency, in any state.
REQ-029 Read and write to the same address in one cycle: readback returns the old content.
REQ-030 Memory is not reset; unwritten locations read undefined.
REQ-031 Counters never wrap: key_count <= KEY_LEN, err_count <= key_count.

Reset
REQ-032 rst_n low: state IDLE, in_ready 0, key_we 0, key_addr 0, key_a 0, key_b 0, rd_a 0, rd_b 0, busy 0, done 0, aborted 0, all counters 0.
REQ-033 Reset mid-block discards the block; only start after rst_n rises begins a new one.
REQ-034 Beats presented while rst_n is low or in IDLE are ignored and not counted.

Configuration
REQ-035 Macro QBER_ABORT_EN defined: the accept that makes err_count reach ERR_LIMIT moves SIFT to ABORT. That pair is still written. ABORT takes priority over DONE on the same edge. ABORT: aborted = 1, in_ready 0, counters hold until start.
REQ-036 QBER_ABORT_EN undefined: ERR_LIMIT ignored, ABORT unreachable, aborted tied 0.

Verification
REQ-037 Defaults, start, 8 beats, all bases equal, bits equal -> key_we 8 times at addr 0..7, key_count 8, err_count 0, disc_count 0, state SIFT.
REQ-038 KEY_LEN=4, 6 beats valid back-to-back, bases equal -> 4 writes, done = 1 the cycle after the 4th accept, beats 5-6 not accepted, key_count 4.
REQ-039 BASIS_W=2, beats with bases (2,2),(1,3),(0,0),(3,1) -> 2 writes at addr 0,1, disc_count 2.
REQ-040 QBER_ABORT_EN, ERR_LIMIT=3, 5 matched beats all with bit mismatch -> 3 writes, aborted = 1, err_count 3, in_ready 0; a start pulse then clears all and re-enters SIFT.
REQ-041 rst_n low after 5 sifted pairs -> all outputs 0; start then 2 pairs -> writes at addr 0,1, key_count 2.
REQ-042 Readback after a block writing pattern 1,0,1 to key_a -> rd_addr 0,1,2 gives rd_a 1,0,1 one cycle later each; same-address read during write returns the old value.
